// File: rtl/inst_rom_if.sv
// Bus bundle for inst_rom: the CPU fetch port plus the host byte-stream
// programming port and the load status outputs.
interface inst_rom_if #(
    parameter int DEPTH_LOG2 = 10
);
    logic [31:0]         romAddr_i;
    logic [31:0]         romData_o;
    logic                loadStart_i;
    logic                loadValid_i;
    logic [7:0]          loadByte_i;
    logic                loadEnd_i;
    logic                loadReady_o;
    logic                loadDone_o;
    logic                cpuRst_o;
    logic [DEPTH_LOG2:0] wordCount_o;

    // ROM side
    modport slave (
        input  romAddr_i, loadStart_i, loadValid_i, loadByte_i, loadEnd_i,
        output romData_o, loadReady_o, loadDone_o, cpuRst_o, wordCount_o
    );

    // CPU / host side
    modport master (
        output romAddr_i, loadStart_i, loadValid_i, loadByte_i, loadEnd_i,
        input  romData_o, loadReady_o, loadDone_o, cpuRst_o, wordCount_o
    );
endinterface

// File: rtl/inst_rom.sv
// Loadable instruction ROM. A host streams program bytes (big-endian per
// word) while the CPU is held in reset; once the stream ends or the memory
// fills, the CPU is released and fetches words combinationally by byte address.
module inst_rom #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic     clk,
    input  logic     rst,
    inst_rom_if.slave bus
);
    localparam int                  DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT  = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [32:0]         ROM_BYTES = 33'd4 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t                state, nextState;
    logic [1:0]            byteCnt;
    logic [DEPTH_LOG2-1:0] wrPtr;
    logic [DEPTH_LOG2:0]   wordCount;
    logic [31:0]           asmWord;
    logic [31:0]           mem [DEPTH];

    logic                  full, accept, clearCnt;
    logic [31:0]           mergedWord;
    logic                  writeEn;
    logic [31:0]           writeData;
    logic [DEPTH_LOG2-1:0] rdIdx;
    logic                  rdValid;

    assign full     = (wordCount == FULL_CNT);
    assign accept   = bus.loadValid_i && bus.loadReady_o;
    // A (re)start from IDLE or RUN wipes the load bookkeeping.
    assign clearCnt = (state != LOAD) && bus.loadStart_i;

    // Place the incoming byte into its big-endian lane; a fresh word starts
    // from zero so a truncated final word comes out zero-padded.
    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        mergedWord = (byteCnt == 2'd0) ? 32'h0 : asmWord;
        case (byteCnt)
            2'd0:    mergedWord[31:24] = bus.loadByte_i;
            2'd1:    mergedWord[23:16] = bus.loadByte_i;
            2'd2:    mergedWord[15:8]  = bus.loadByte_i;
            default: mergedWord[7:0]   = bus.loadByte_i;
        endcase
    end

    // Next-state and write-strobe decode.
    always_comb begin
        nextState = state;
        writeEn   = 1'b0;
        writeData = mergedWord;
        case (state)
            IDLE: if (bus.loadStart_i) nextState = LOAD;
            LOAD: begin
                if (full) begin
                    nextState = RUN;
                end else begin
                    if (accept && byteCnt == 2'd3) writeEn = 1'b1;
                    if (bus.loadEnd_i) begin
                        nextState = RUN;
                        // The byte arriving with loadEnd is taken first; only a
                        // still-incomplete word needs flushing.
                        if (accept && byteCnt != 2'd3) begin
                            writeEn = 1'b1;
                        end else if (!accept && byteCnt != 2'd0) begin
                            writeEn   = 1'b1;
                            writeData = asmWord;
                        end
                    end
                end
            end
            RUN:  if (bus.loadStart_i) nextState = LOAD;
            default: nextState = IDLE;
        endcase
    end

    // State register and load bookkeeping.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            byteCnt   <= 2'd0;
            wrPtr     <= '0;
            wordCount <= '0;
            asmWord   <= 32'h0;
        end else begin
            state <= nextState;
            if (clearCnt) begin
                byteCnt   <= 2'd0;
                wrPtr     <= '0;
                wordCount <= '0;
                asmWord   <= 32'h0;
            end else begin
                if (accept) begin
                    byteCnt <= byteCnt + 2'd1;
                    asmWord <= mergedWord;
                end
                if (writeEn) begin
                    wrPtr     <= wrPtr + 1'b1;
                    wordCount <= wordCount + 1'b1;
                end
            end
        end
    end

    // Program storage write port.
    // NOTE: the array has no reset; stale words stay hidden behind wordCount.
    always_ff @(posedge clk) begin
        if (writeEn) mem[wrPtr] <= writeData;
    end

    // Combinational fetch, masked beyond the array and beyond loaded words.
    assign rdIdx   = bus.romAddr_i[DEPTH_LOG2+1:2];
    assign rdValid = ({1'b0, bus.romAddr_i} < ROM_BYTES) && ({1'b0, rdIdx} < wordCount);

    always_comb begin
        bus.romData_o = 32'h0;
        if (rdValid) bus.romData_o = mem[rdIdx];
    end

    assign bus.loadReady_o = (state == LOAD) && !full;
    assign bus.loadDone_o  = (state == RUN);
    assign bus.cpuRst_o    = (state != RUN);
    assign bus.wordCount_o = wordCount;
endmodule

// File: tb/tb_inst_rom.sv
// Directed bench for inst_rom: a 4-word instance exercises fill/overflow and
// most scenarios; a default 1024-word instance shares the same stimulus.
module tb_inst_rom;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] romAddr = 32'h0;
    logic        loadStart = 1'b0;
    logic        loadValid = 1'b0;
    logic [7:0]  loadByte = 8'h0;
    logic        loadEnd = 1'b0;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    inst_rom_if #(.DEPTH_LOG2(2)) busS ();
    inst_rom_if                   busB ();

    assign busS.romAddr_i   = romAddr;
    assign busS.loadStart_i = loadStart;
    assign busS.loadValid_i = loadValid;
    assign busS.loadByte_i  = loadByte;
    assign busS.loadEnd_i   = loadEnd;
    assign busB.romAddr_i   = romAddr;
    assign busB.loadStart_i = loadStart;
    assign busB.loadValid_i = loadValid;
    assign busB.loadByte_i  = loadByte;
    assign busB.loadEnd_i   = loadEnd;

    inst_rom #(.DEPTH_LOG2(2)) dutS (.clk(clk), .rst(rst), .bus(busS));
    inst_rom                   dutB (.clk(clk), .rst(rst), .bus(busB));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic readAt(input logic [31:0] a);
        romAddr = a;
        #1;
    endtask

    task automatic sendByte(input logic [7:0] b, input logic e);
        loadValid = 1'b1;
        loadByte  = b;
        loadEnd   = e;
        tick();
        loadValid = 1'b0;
        loadEnd   = 1'b0;
    endtask

    task automatic startLoad();
        loadStart = 1'b1;
        tick();
        loadStart = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        readAt(32'h0);
        nChecks++; if (busS.loadReady_o !== 1'b0) begin nFails++; $display("FAIL reset_ready: got %b want 0", busS.loadReady_o); end
        nChecks++; if (busS.loadDone_o !== 1'b0) begin nFails++; $display("FAIL reset_done: got %b want 0", busS.loadDone_o); end
        nChecks++; if (busS.cpuRst_o !== 1'b1) begin nFails++; $display("FAIL reset_cpurst: got %b want 1", busS.cpuRst_o); end
        nChecks++; if (busS.wordCount_o !== 3'd0) begin nFails++; $display("FAIL reset_count: got %0d want 0", busS.wordCount_o); end
        nChecks++; if (busS.romData_o !== 32'h0) begin nFails++; $display("FAIL reset_data: got %h want 0", busS.romData_o); end
        nChecks++; if (busB.cpuRst_o !== 1'b1) begin nFails++; $display("FAIL reset_cpurst_big: got %b want 1", busB.cpuRst_o); end
    endtask

    task automatic test_full();
        startLoad();
        nChecks++; if (busS.loadReady_o !== 1'b1) begin nFails++; $display("FAIL full_ready_start: got %b want 1", busS.loadReady_o); end
        for (int i = 1; i <= 20; i++) begin
            loadValid = 1'b1;
            loadByte  = 8'(i);
            tick();
            if (i == 16) begin
                nChecks++; if (busS.loadReady_o !== 1'b0) begin nFails++; $display("FAIL full_ready_at16: got %b want 0", busS.loadReady_o); end
                nChecks++; if (busS.loadDone_o !== 1'b0) begin nFails++; $display("FAIL full_done_at16: got %b want 0", busS.loadDone_o); end
            end
            if (i == 17) begin
                nChecks++; if (busS.loadDone_o !== 1'b1) begin nFails++; $display("FAIL full_done_at17: got %b want 1", busS.loadDone_o); end
            end
        end
        loadValid = 1'b0;
        nChecks++; if (busS.wordCount_o !== 3'd4) begin nFails++; $display("FAIL full_count: got %0d want 4", busS.wordCount_o); end
        readAt(32'd16);
        nChecks++; if (busS.romData_o !== 32'h0) begin nFails++; $display("FAIL full_rd16: got %h want 0", busS.romData_o); end
        readAt(32'd13);
        nChecks++; if (busS.romData_o !== 32'h0D0E0F10) begin nFails++; $display("FAIL full_rd13: got %h want 0d0e0f10", busS.romData_o); end
        readAt(32'd0);
        nChecks++; if (busS.romData_o !== 32'h01020304) begin nFails++; $display("FAIL full_rd0: got %h want 01020304", busS.romData_o); end
        readAt(32'd6);
        nChecks++; if (busS.romData_o !== 32'h05060708) begin nFails++; $display("FAIL full_rd6: got %h want 05060708", busS.romData_o); end
    endtask

    // Small DUT restarts from RUN; big DUT is still in LOAD and ignores the start.
    task automatic test_partial();
        startLoad();
        sendByte(8'hAA, 1'b0);
        sendByte(8'hBB, 1'b0);
        sendByte(8'hCC, 1'b1);
        nChecks++; if (busS.wordCount_o !== 3'd1) begin nFails++; $display("FAIL partial_count: got %0d want 1", busS.wordCount_o); end
        nChecks++; if (busS.loadDone_o !== 1'b1) begin nFails++; $display("FAIL partial_done: got %b want 1", busS.loadDone_o); end
        readAt(32'd0);
        nChecks++; if (busS.romData_o !== 32'hAABBCC00) begin nFails++; $display("FAIL partial_rd0: got %h want aabbcc00", busS.romData_o); end
        readAt(32'd4);
        nChecks++; if (busS.romData_o !== 32'h0) begin nFails++; $display("FAIL partial_rd4_masked: got %h want 0", busS.romData_o); end
        nChecks++; if (busB.wordCount_o !== 11'd6) begin nFails++; $display("FAIL partial_big_count: got %0d want 6", busB.wordCount_o); end
        readAt(32'd20);
        nChecks++; if (busB.romData_o !== 32'hAABBCC00) begin nFails++; $display("FAIL partial_big_rd20: got %h want aabbcc00", busB.romData_o); end
    endtask

    task automatic test_basic();
        logic [7:0] prog [8] = '{8'h24, 8'h02, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
        startLoad();
        nChecks++; if (busB.cpuRst_o !== 1'b1) begin nFails++; $display("FAIL basic_cpurst_load: got %b want 1", busB.cpuRst_o); end
        for (int i = 0; i < 8; i++) sendByte(prog[i], 1'b0);
        loadEnd = 1'b1;
        tick();
        loadEnd = 1'b0;
        nChecks++; if (busB.wordCount_o !== 11'd2) begin nFails++; $display("FAIL basic_count: got %0d want 2", busB.wordCount_o); end
        nChecks++; if (busB.loadDone_o !== 1'b1) begin nFails++; $display("FAIL basic_done: got %b want 1", busB.loadDone_o); end
        nChecks++; if (busB.cpuRst_o !== 1'b0) begin nFails++; $display("FAIL basic_cpurst_run: got %b want 0", busB.cpuRst_o); end
        nChecks++; if (busB.loadReady_o !== 1'b0) begin nFails++; $display("FAIL basic_ready_run: got %b want 0", busB.loadReady_o); end
        nChecks++; if (busS.wordCount_o !== 3'd2) begin nFails++; $display("FAIL basic_small_count: got %0d want 2", busS.wordCount_o); end
        readAt(32'd0);
        nChecks++; if (busB.romData_o !== 32'h24020005) begin nFails++; $display("FAIL basic_rd0: got %h want 24020005", busB.romData_o); end
        readAt(32'd3);
        nChecks++; if (busS.romData_o !== 32'h24020005) begin nFails++; $display("FAIL basic_rd3_small: got %h want 24020005", busS.romData_o); end
        readAt(32'd4);
        nChecks++; if (busB.romData_o !== 32'h0) begin nFails++; $display("FAIL basic_rd4: got %h want 0", busB.romData_o); end
        readAt(32'd8);
        nChecks++; if (busB.romData_o !== 32'h0) begin nFails++; $display("FAIL basic_rd8: got %h want 0", busB.romData_o); end
        nChecks++; if (busS.romData_o !== 32'h0) begin nFails++; $display("FAIL basic_rd8_small: got %h want 0", busS.romData_o); end
    endtask

    task automatic test_reprogram();
        logic [7:0] prog [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        nChecks++; if (busS.cpuRst_o !== 1'b0) begin nFails++; $display("FAIL reprog_cpurst_before: got %b want 0", busS.cpuRst_o); end
        startLoad();
        for (int i = 0; i < 4; i++) begin
            nChecks++; if (busS.cpuRst_o !== 1'b1) begin nFails++; $display("FAIL reprog_cpurst_load%0d: got %b want 1", i, busS.cpuRst_o); end
            sendByte(prog[i], 1'b0);
        end
        nChecks++; if (busS.cpuRst_o !== 1'b1) begin nFails++; $display("FAIL reprog_cpurst_pre_end: got %b want 1", busS.cpuRst_o); end
        loadEnd = 1'b1;
        tick();
        loadEnd = 1'b0;
        nChecks++; if (busS.loadDone_o !== 1'b1) begin nFails++; $display("FAIL reprog_done: got %b want 1", busS.loadDone_o); end
        nChecks++; if (busS.wordCount_o !== 3'd1) begin nFails++; $display("FAIL reprog_count: got %0d want 1", busS.wordCount_o); end
        readAt(32'd0);
        nChecks++; if (busS.romData_o !== 32'h11223344) begin nFails++; $display("FAIL reprog_rd0: got %h want 11223344", busS.romData_o); end
    endtask

    task automatic test_stall();
        logic       vPat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [7:0] bytes [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        int         k = 0;
        startLoad();
        for (int i = 0; i < 7; i++) begin
            loadValid = vPat[i];
            loadByte  = vPat[i] ? bytes[k] : 8'hFF;
            if (vPat[i]) k++;
            tick();
            if (i == 5) begin
                nChecks++; if (busS.wordCount_o !== 3'd0) begin nFails++; $display("FAIL stall_count_early: got %0d want 0", busS.wordCount_o); end
            end
        end
        loadValid = 1'b0;
        nChecks++; if (busS.wordCount_o !== 3'd1) begin nFails++; $display("FAIL stall_count: got %0d want 1", busS.wordCount_o); end
        loadEnd = 1'b1;
        tick();
        loadEnd = 1'b0;
        nChecks++; if (busS.wordCount_o !== 3'd1) begin nFails++; $display("FAIL stall_count_end: got %0d want 1", busS.wordCount_o); end
        readAt(32'd0);
        nChecks++; if (busS.romData_o !== 32'hA1B2C3D4) begin nFails++; $display("FAIL stall_rd0: got %h want a1b2c3d4", busS.romData_o); end
    endtask

    task automatic test_midload_reset();
        startLoad();
        for (int i = 0; i < 6; i++) sendByte(8'h50 + 8'(i), 1'b0);
        nChecks++; if (busS.wordCount_o !== 3'd1) begin nFails++; $display("FAIL midrst_count_before: got %0d want 1", busS.wordCount_o); end
        rst = 1'b1;
        loadValid = 1'b1;
        loadByte  = 8'h99;
        loadEnd   = 1'b1;
        tick();
        rst = 1'b0;
        loadValid = 1'b0;
        loadEnd   = 1'b0;
        nChecks++; if (busS.cpuRst_o !== 1'b1) begin nFails++; $display("FAIL midrst_cpurst: got %b want 1", busS.cpuRst_o); end
        nChecks++; if (busS.loadDone_o !== 1'b0) begin nFails++; $display("FAIL midrst_done: got %b want 0", busS.loadDone_o); end
        nChecks++; if (busS.loadReady_o !== 1'b0) begin nFails++; $display("FAIL midrst_ready: got %b want 0", busS.loadReady_o); end
        nChecks++; if (busS.wordCount_o !== 3'd0) begin nFails++; $display("FAIL midrst_count: got %0d want 0", busS.wordCount_o); end
        nChecks++; if (busB.wordCount_o !== 11'd0) begin nFails++; $display("FAIL midrst_count_big: got %0d want 0", busB.wordCount_o); end
        for (int a = 0; a <= 20; a += 4) begin
            readAt(32'(a));
            nChecks++; if (busS.romData_o !== 32'h0) begin nFails++; $display("FAIL midrst_rd%0d: got %h want 0", a, busS.romData_o); end
            nChecks++; if (busB.romData_o !== 32'h0) begin nFails++; $display("FAIL midrst_rd%0d_big: got %h want 0", a, busB.romData_o); end
        end
    endtask

    initial begin
        test_reset();
        test_full();
        test_partial();
        test_basic();
        test_reprogram();
        test_stall();
        test_midload_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/inst_rom.md
INST_ROM -- requirements
Module: inst_rom

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 10, giving the log2 of the number of 32-bit instruction words (1024).
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 romAddr_i  input  32  CPU fetch byte address (the pc).
REQ-005 romData_o  output  32  instruction word for romAddr_i, combinational (same-cycle) read.
REQ-006 loadStart_i  input  1  host request to (re)program the memory.
REQ-007 loadValid_i  input  1  loadByte_i is valid this cycle.
REQ-008 loadByte_i  input  8  program byte stream, big-endian within each word.
REQ-009 loadEnd_i  input  1  host marks the end of the program stream.
REQ-010 loadReady_o  output  1  block accepts a byte this cycle.
REQ-011 loadDone_o  output  1  level, high while in RUN.
REQ-012 cpuRst_o  output  1  holds the CPU in reset while not in RUN.
REQ-013 wordCount_o  output  DEPTH_LOG2+1  number of valid words loaded.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD and RUN, encoded in 2 bits.
REQ-015 IDLE: on loadStart_i=1 the FSM SHALL go to LOAD next cycle and clear byteCnt, wrPtr and wordCount; otherwise it stays in IDLE.
REQ-016 LOAD: loadReady_o SHALL equal 1 while wordCount < 2^DEPTH_LOG2; a byte is accepted when loadValid_i && loadReady_o.
REQ-017 Byte assembly: accepted byte k (k = byteCnt, 0..3) SHALL go to word bits [31-8k : 24-8k]; byteCnt wraps from 3 to 0.
REQ-018 On the 4th accepted byte the assembled word SHALL be written to mem[wrPtr]; wrPtr and wordCount increment in the same cycle.
REQ-019 When wordCount reaches 2^DEPTH_LOG2 (full), the FSM SHALL go to RUN automatically on the next cycle; bytes offered while full are dropped.
REQ-020 loadEnd_i in LOAD with byteCnt != 0: the partial word, zero-padded in its low bytes, SHALL be written and counted, and the FSM goes to RUN.
REQ-021 loadEnd_i in LOAD with byteCnt = 0: the FSM SHALL go to RUN with no extra write.
REQ-022 loadValid_i and loadEnd_i in the same cycle: the byte SHALL be accepted first, then the REQ-020/021 rule applies to the resulting byteCnt.
REQ-023 loadStart_i while in LOAD SHALL be ignored.
REQ-024 RUN: loadDone_o=1, cpuRst_o=0 and loadReady_o=0; loadStart_i SHALL return the FSM to LOAD (via the REQ-015 clear), with cpuRst_o=1 from the next cycle.
REQ-025 cpuRst_o SHALL be 1 in IDLE and in LOAD.
REQ-026 Read index: romData_o SHALL equal mem[romAddr_i[DEPTH_LOG2+1:2]]; romAddr_i[1:0] are ignored.
REQ-027 romData_o SHALL be 32'h0 when romAddr_i >= 4*2^DEPTH_LOG2 or when the word index is >= wordCount.
REQ-028 A word written in cycle N SHALL be readable from cycle N+1; there is no write-to-read bypass within the same cycle.

Reset
REQ-029 On rst=1 at a clock edge the FSM SHALL enter IDLE, and byteCnt, wrPtr and wordCount SHALL clear to 0.
REQ-030 Output values after reset SHALL be: loadReady_o=0, loadDone_o=0, cpuRst_o=1, wordCount_o=0, romData_o=0 (through the REQ-027 masking).
REQ-031 The memory array SHALL NOT be reset; stale contents are hidden by wordCount.
REQ-032 rst SHALL take priority over every other input, including a reset that arrives mid-load, where the partial word is discarded.

Verification
REQ-033 Reset, then loadStart; send bytes 24,02,00,05,00,00,00,00; pulse loadEnd -> wordCount_o=2, loadDone_o=1, cpuRst_o=0; romAddr_i=0 gives 32'h24020005, romAddr_i=4 gives 0, romAddr_i=8 gives 0.
REQ-034 Partial word: bytes AA,BB,CC with loadEnd on the cycle of CC -> mem[0]=32'hAABBCC00, wordCount_o=1.
REQ-035 Full wrap with DEPTH_LOG2=2: send 20 bytes -> the FSM reaches RUN after 16 bytes, bytes 17-20 are dropped, wordCount_o=4, romAddr_i=16 gives 0, romAddr_i=13 reads mem[3].
REQ-036 Reset mid-load after 6 bytes -> IDLE, cpuRst_o=1, wordCount_o=0, romData_o=0 at every address.
REQ-037 Reprogram from RUN: a new loadStart with 4 bytes 11,22,33,44 -> cpuRst_o=1 throughout LOAD, then RUN with wordCount_o=1 and romAddr_i=0 reading 32'h11223344.
REQ-038 Stalled host: loadValid_i toggling 1,0,0,1,1,0,1 -> exactly 4 bytes assembled in order, with a single write.
